// File: rtl/aes_key_expander.sv
// Iterative AES-128/192/256 key schedule with NUM_SLOTS stored schedules.
// Ports: load_* key-load handshake, busy/done/slot_valid status, rd_* keyed read.
module aes_key_expander #(
    parameter int NUM_SLOTS  = 2,
    parameter bit ENABLE_192 = 1'b1,
    localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [1:0]           load_mode,
    input  logic [SLOT_W-1:0]    load_slot,
    input  logic [255:0]         load_key,
    output logic                 load_err,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_SLOTS-1:0] slot_valid,
    input  logic                 rd_en,
    input  logic [SLOT_W-1:0]    rd_slot,
    input  logic [3:0]           rd_round,
    output logic                 rd_valid,
    output logic [127:0]         rd_key,
    output logic                 rd_err
);

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b
            ^ {b[6:0], b[7]}
            ^ {b[5:0], b[7:6]}
            ^ {b[4:0], b[7:5]}
            ^ {b[3:0], b[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]),  sbox(w[7:0])};
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] m);
        unique case (m)
            2'b01:   return 4'd6;
            2'b10:   return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        unique case (m)
            2'b01:   return 4'd12;
            2'b10:   return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] last_of(input logic [1:0] m);
        unique case (m)
            2'b01:   return 6'd51;
            2'b10:   return 6'd59;
            default: return 6'd43;
        endcase
    endfunction

    state_t              state;
    logic [1:0]          mode_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [5:0]          idx_q;
    logic [2:0]          imod_q;
    logic [7:0]          rcon_q;
    logic [1:0]          slot_mode_q [NUM_SLOTS];

    // win_q[7] = w[i-1], win_q[8-Nk] = w[i-Nk].
    logic [31:0]         win_q [8];
    logic [31:0]         mem   [NUM_SLOTS][64];

    logic                mode_ok;
    logic                slot_ok;
    logic                legal;
    logic                accept;
    logic [255:0]        key_al;
    logic [3:0]          nk;
    logic [2:0]          imod_max;
    logic [31:0]         prev;
    logic [31:0]         old;
    logic [31:0]         rot;
    logic [31:0]         sub;
    logic [31:0]         temp;
    logic [31:0]         new_w;
    logic                last;

    logic                rd_slot_ok;
    logic [SLOT_W-1:0]   rd_idx;
    logic [3:0]          rd_nr;
    logic                rd_bad;
    logic [5:0]          rd_base;
    logic [127:0]        rd_word;

    assign load_ready = (state == IDLE);

    assign mode_ok = (load_mode == 2'b00)
                   | (load_mode == 2'b10)
                   | ((load_mode == 2'b01) & ENABLE_192);
    assign slot_ok = int'(load_slot) < NUM_SLOTS;
    assign legal   = mode_ok & slot_ok;
    assign accept  = load_valid & load_ready;

    // Left-align the key so w0 always sits in [255:224].
    always_comb begin
        key_al = load_key;
        unique case (load_mode)
            2'b00:   key_al = {load_key[127:0], 128'h0};
            2'b01:   key_al = {load_key[191:0], 64'h0};
            default: key_al = load_key;
        endcase
    end

    assign nk       = nk_of(mode_q);
    assign imod_max = 3'(nk - 4'd1);
    assign prev     = win_q[7];
    assign rot      = {prev[23:0], prev[31:24]};
    assign sub      = sub_word((imod_q == 3'd0) ? rot : prev);
    assign last     = (idx_q == last_of(mode_q));

    always_comb begin
        old = win_q[4];
        unique case (mode_q)
            2'b01:   old = win_q[2];
            2'b10:   old = win_q[0];
            default: old = win_q[4];
        endcase
    end

    always_comb begin
        temp = prev;
        unique case (1'b1)
            (imod_q == 3'd0):
                temp = sub ^ {rcon_q, 24'h0};
            (nk == 4'd8 && imod_q == 3'd4):
                temp = sub;
            default:
                temp = prev;
        endcase
    end

    assign new_w = old ^ temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_err   <= 1'b0;
            slot_valid <= '0;
            mode_q     <= 2'b00;
            slot_q     <= '0;
            idx_q      <= 6'd0;
            imod_q     <= 3'd0;
            rcon_q     <= 8'h01;
            for (int s = 0; s < NUM_SLOTS; s++)
                slot_mode_q[s] <= 2'b00;
        end else begin
            done     <= 1'b0;
            load_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && !legal) begin
                        load_err <= 1'b1;
                    end else if (accept) begin
                        mode_q                 <= load_mode;
                        slot_q                 <= load_slot;
                        slot_valid[load_slot]  <= 1'b0;
                        slot_mode_q[load_slot] <= load_mode;
                        idx_q                  <= {2'b00, nk_of(load_mode)};
                        imod_q                 <= 3'd0;
                        rcon_q                 <= 8'h01;
                        busy                   <= 1'b1;
                        state                  <= EXPAND;
                    end
                end
                EXPAND: begin
                    idx_q  <= idx_q + 6'd1;
                    imod_q <= (imod_q == imod_max) ? 3'd0 : imod_q + 3'd1;
                    if (imod_q == 3'd0)
                        rcon_q <= xtime(rcon_q);
                    if (last) begin
                        slot_valid[slot_q] <= 1'b1;
                        done               <= 1'b1;
                        busy               <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Extra key words written at accept for short keys are
    // overwritten by expansion before the slot becomes valid.
    always_ff @(posedge clk) begin
        if (accept && legal) begin
            for (int k = 0; k < 8; k++) begin
                mem[load_slot][k] <= key_al[255-32*k -: 32];
                win_q[k]          <= load_key[255-32*k -: 32];
            end
        end else if (state == EXPAND) begin
            mem[slot_q][idx_q] <= new_w;
            for (int k = 0; k < 7; k++)
                win_q[k] <= win_q[k+1];
            win_q[7] <= new_w;
        end
    end

    assign rd_slot_ok = int'(rd_slot) < NUM_SLOTS;
    assign rd_idx     = rd_slot_ok ? rd_slot : '0;
    assign rd_nr      = nr_of(slot_mode_q[rd_idx]);
    assign rd_bad     = !rd_slot_ok
                      | !slot_valid[rd_idx]
                      | (rd_round > rd_nr);
    assign rd_base    = {rd_round, 2'b00};
    assign rd_word    = {mem[rd_idx][rd_base],
                         mem[rd_idx][rd_base + 6'd1],
                         mem[rd_idx][rd_base + 6'd2],
                         mem[rd_idx][rd_base + 6'd3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            rd_key   <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_err <= rd_bad;
                rd_key <= rd_bad ? 128'h0 : rd_word;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key schedules.
// Checks reset, latency, reads, error paths, busy-load and async reset.
module tb_aes_key_expander;

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_3 = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] R128_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [191:0] K192   =
        192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [127:0] R192_0 = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R192_C = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [255:0] K256   =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_0 = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] R256_1 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_E = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [1:0]   load_mode;
    logic [0:0]   load_slot;
    logic [255:0] load_key;
    logic         load_err;
    logic         busy;
    logic         done;
    logic [1:0]   slot_valid;
    logic         rd_en;
    logic [0:0]   rd_slot;
    logic [3:0]   rd_round;
    logic         rd_valid;
    logic [127:0] rd_key;
    logic         rd_err;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int start      = 0;

    always #5 clk = ~clk;

    aes_key_expander #(.NUM_SLOTS(2), .ENABLE_192(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_mode(load_mode), .load_slot(load_slot),
        .load_key(load_key), .load_err(load_err),
        .busy(busy), .done(done), .slot_valid(slot_valid),
        .rd_en(rd_en), .rd_slot(rd_slot), .rd_round(rd_round),
        .rd_valid(rd_valid), .rd_key(rd_key), .rd_err(rd_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(
        input string        tag,
        input logic [127:0] obs,
        input logic [127:0] exp
    );
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(
        input logic [1:0]   m,
        input logic [0:0]   s,
        input logic [255:0] k
    );
        load_valid = 1'b1;
        load_mode  = m;
        load_slot  = s;
        load_key   = k;
        tick();
        load_valid = 1'b0;
        start      = cyc;
    endtask

    task automatic read_chk(
        input string        tag,
        input logic [0:0]   s,
        input logic [3:0]   r,
        input logic [127:0] exp_key,
        input logic         exp_err
    );
        rd_en    = 1'b1;
        rd_slot  = s;
        rd_round = r;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 128'(rd_valid), 128'd1);
        chk({tag, "_key"}, rd_key, exp_key);
        chk({tag, "_err"}, 128'(rd_err), 128'(exp_err));
    endtask

    task automatic wait_done(input string tag, input int lat);
        bit seen;
        seen = 1'b0;
        for (int j = 0; j < 200 && !seen; j++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 128'(seen), 128'd1);
        chk({tag, "_latency"}, 128'(cyc - start), 128'(lat));
        chk({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    endtask

    initial begin
        rst_n      = 1'b1;
        load_valid = 1'b0;
        load_mode  = 2'b00;
        load_slot  = 1'b0;
        load_key   = '0;
        rd_en      = 1'b0;
        rd_slot    = 1'b0;
        rd_round   = 4'd0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_ready", 128'(load_ready), 128'd1);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_load_err", 128'(load_err), 128'd0);
        chk("rst_rd_valid", 128'(rd_valid), 128'd0);
        chk("rst_rd_err", 128'(rd_err), 128'd0);
        chk("rst_rd_key", rd_key, 128'd0);
        chk("rst_slot_valid", 128'(slot_valid), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_load(2'b00, 1'b0, {128'h0, K128});
        chk("a128_busy", 128'(busy), 128'd1);
        chk("a128_ready", 128'(load_ready), 128'd0);
        wait_done("a128", 40);
        chk("a128_slot_valid", 128'(slot_valid), 128'd1);
        tick();
        chk("a128_done_pulse", 128'(done), 128'd0);
        chk("a128_ready_idle", 128'(load_ready), 128'd1);
        read_chk("a128_r0", 1'b0, 4'd0, K128, 1'b0);
        read_chk("a128_r3", 1'b0, 4'd3, R128_3, 1'b0);
        read_chk("a128_r10", 1'b0, 4'd10, R128_A, 1'b0);
        read_chk("a128_r11", 1'b0, 4'd11, 128'd0, 1'b1);
        read_chk("inv_slot1", 1'b1, 4'd0, 128'd0, 1'b1);

        do_load(2'b11, 1'b1, K256);
        chk("bad_mode_err", 128'(load_err), 128'd1);
        chk("bad_mode_busy", 128'(busy), 128'd0);
        chk("bad_mode_sv", 128'(slot_valid), 128'd1);
        tick();
        chk("bad_mode_pulse", 128'(load_err), 128'd0);

        do_load(2'b01, 1'b1, {64'h0, K192});
        chk("a192_busy", 128'(busy), 128'd1);
        rd_en    = 1'b1;
        rd_slot  = 1'b0;
        rd_round = 4'd3;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("pipe_valid", 128'(rd_valid), 128'd1);
            chk("pipe_key", rd_key, R128_3);
            chk("pipe_err", 128'(rd_err), 128'd0);
        end
        rd_slot  = 1'b1;
        rd_round = 4'd0;
        tick();
        chk("exp_slot_err", 128'(rd_err), 128'd1);
        chk("exp_slot_key", rd_key, 128'd0);
        rd_en = 1'b0;
        tick();
        chk("idle_rd_valid", 128'(rd_valid), 128'd0);
        chk("idle_rd_err_hold", 128'(rd_err), 128'd1);
        load_valid = 1'b1;
        load_mode  = 2'b00;
        load_slot  = 1'b0;
        load_key   = '1;
        tick();
        load_valid = 1'b0;
        chk("busy_load_sv", 128'(slot_valid), 128'd1);
        chk("busy_load_busy", 128'(busy), 128'd1);
        wait_done("a192", 46);
        chk("a192_slot_valid", 128'(slot_valid), 128'd3);
        read_chk("a192_r0", 1'b1, 4'd0, R192_0, 1'b0);
        read_chk("a192_r12", 1'b1, 4'd12, R192_C, 1'b0);
        read_chk("a192_r13", 1'b1, 4'd13, 128'd0, 1'b1);
        read_chk("busy_load_kept", 1'b0, 4'd10, R128_A, 1'b0);

        do_load(2'b10, 1'b0, K256);
        chk("a256_sv_clear", 128'(slot_valid), 128'd2);
        wait_done("a256", 52);
        read_chk("a256_r0", 1'b0, 4'd0, R256_0, 1'b0);
        read_chk("a256_r1", 1'b0, 4'd1, R256_1, 1'b0);
        read_chk("a256_r14", 1'b0, 4'd14, R256_E, 1'b0);
        read_chk("a256_r15", 1'b0, 4'd15, 128'd0, 1'b1);

        do_load(2'b00, 1'b1, {128'h0, K128});
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_sv", 128'(slot_valid), 128'd0);
        chk("mid_rst_ready", 128'(load_ready), 128'd1);
        @(negedge clk) rst_n = 1'b1;
        do_load(2'b00, 1'b1, {128'h0, K128});
        wait_done("reload", 40);
        read_chk("reload_r10", 1'b1, 4'd10, R128_A, 1'b0);
        read_chk("reload_r3", 1'b1, 4'd3, R128_3, 1'b0);
        read_chk("reload_slot0_inv", 1'b0, 4'd0, 128'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
